// File: rtl/exp_seq_ctrl.sv
// exp_seq_ctrl: sequential e^x evaluator (Taylor series) for an unsigned
// Q16.16 operand, producing an unsigned Q32.32 result. One 64x32 multiplier
// and one bit-serial restoring divider are shared by every series term.
// Optional build macro: EXP_SEQ_EARLY_EXIT_EN (finish as soon as a term
// becomes zero; the result is unchanged because every later term is zero).
module exp_seq_ctrl #(
    parameter int N_TERMS = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [63:0] res,
    output logic        ovf
);

    localparam logic [63:0] ONE_Q32 = 64'h0000_0001_0000_0000;
    localparam logic [63:0] SAT_Q32 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [5:0]  LAST_N  = 6'(N_TERMS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_ACC,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_x;
    logic [63:0] r_term;     // running term; doubles as divider shift register
    logic [63:0] r_sum;
    logic [5:0]  r_n;
    logic [5:0]  r_cnt;      // divide step counter
    logic [5:0]  r_rem;      // partial remainder, always < n
    logic        r_ovf_acc;  // sticky overflow for the computation in flight
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_res;
    logic        r_ovf;

    logic [95:0] w_prod;
    logic        w_unused_prod_lo;
    logic [6:0]  w_trial;
    logic [6:0]  w_n_ext;
    logic        w_qbit;
    logic [5:0]  w_rem_next;
    logic [63:0] w_q_next;
    logic [64:0] w_sum_ext;
    logic        w_ovf_fin;

    // Shared multiplier: Q32.32 term times Q16.16 operand gives Q48.48.
    assign w_prod           = 96'(r_term) * 96'(r_x);
    assign w_unused_prod_lo = ^w_prod[15:0];

    // One restoring-divide step: bring in the next dividend bit, subtract n
    // when it fits. The remainder stays below n (at most 31), so 6 bits hold it.
    assign w_trial    = {r_rem, r_term[63]};
    assign w_n_ext    = {1'b0, r_n};
    assign w_qbit     = (w_trial >= w_n_ext);
    assign w_rem_next = w_qbit ? 6'(w_trial - w_n_ext) : w_trial[5:0];
    assign w_q_next   = {r_term[62:0], w_qbit};

    // Accumulator add with carry-out feeding the overflow flag.
    assign w_sum_ext  = {1'b0, r_sum} + {1'b0, r_term};
    assign w_ovf_fin  = r_ovf_acc | w_sum_ext[64];

    assign busy = r_busy;
    assign done = r_done;
    assign res  = r_res;
    assign ovf  = r_ovf;

    // Controller FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_term    <= '0;
            r_sum     <= '0;
            r_n       <= '0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_ovf_acc <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x       <= x;
                        r_term    <= ONE_Q32;
                        r_sum     <= ONE_Q32;
                        r_n       <= 6'd1;
                        r_ovf_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_term <= w_prod[79:16];
                    if (w_prod[95:80] != 16'd0) begin
                        r_ovf_acc <= 1'b1;
                    end
                    r_cnt   <= '0;
                    r_rem   <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_term <= w_q_next;
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
`ifdef EXP_SEQ_EARLY_EXIT_EN
                        // A zero term makes all later terms zero: sum is final.
                        if (w_q_next == 64'd0) begin
                            r_res   <= r_ovf_acc ? SAT_Q32 : r_sum;
                            r_ovf   <= r_ovf_acc;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ACC;
                        end
`else
                        r_state <= S_ACC;
`endif
                    end
                end
                S_ACC: begin
                    r_sum <= w_sum_ext[63:0];
                    if (w_sum_ext[64]) begin
                        r_ovf_acc <= 1'b1;
                    end
                    if (r_n == LAST_N) begin
                        r_res   <= w_ovf_fin ? SAT_Q32 : w_sum_ext[63:0];
                        r_ovf   <= w_ovf_fin;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_n     <= r_n + 6'd1;
                        r_state <= S_MUL;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
